// File: rtl/expr_seq_pkg.sv
// expr_seq_pkg: shared definitions for the expression vector sequencer.
//   - seq_state_t : sequencer FSM states
//   - LFSR tap positions, default seed, next-state and seed-guard helpers
//   - operand field offsets/widths for unpacking op_vec into a0..a5, b0..b5
//     (MSB first: a0[3:0], a1[4:0], a2[5:0], a3[3:0], a4[4:0], a5[5:0],
//      then b0..b5 with the same widths)
package expr_seq_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} seq_state_t;

    localparam logic [63:0] LFSR_DEFAULT_SEED = 64'h1;
    localparam int LFSR_TAP0 = 63;
    localparam int LFSR_TAP1 = 62;
    localparam int LFSR_TAP2 = 60;
    localparam int LFSR_TAP3 = 59;

    localparam int A0_OFF = 56;  localparam int A0_W = 4;
    localparam int A1_OFF = 51;  localparam int A1_W = 5;
    localparam int A2_OFF = 45;  localparam int A2_W = 6;
    localparam int A3_OFF = 41;  localparam int A3_W = 4;
    localparam int A4_OFF = 36;  localparam int A4_W = 5;
    localparam int A5_OFF = 30;  localparam int A5_W = 6;
    localparam int B0_OFF = 26;  localparam int B0_W = 4;
    localparam int B1_OFF = 21;  localparam int B1_W = 5;
    localparam int B2_OFF = 15;  localparam int B2_W = 6;
    localparam int B3_OFF = 11;  localparam int B3_W = 4;
    localparam int B4_OFF = 6;   localparam int B4_W = 5;
    localparam int B5_OFF = 0;   localparam int B5_W = 6;

    // Fibonacci step: shift left, feedback into the LSB.
    function automatic logic [63:0] lfsr64_next(input logic [63:0] l);
        return {l[62:0], l[LFSR_TAP0] ^ l[LFSR_TAP1] ^ l[LFSR_TAP2] ^ l[LFSR_TAP3]};
    endfunction

    // An all-zero state would lock the LFSR, so a zero seed is replaced.
    function automatic logic [63:0] lfsr64_seed(input logic [63:0] s);
        return (s == 64'h0) ? LFSR_DEFAULT_SEED : s;
    endfunction

    // Extract one operand field (width up to 6) from a packed vector.
    function automatic logic [5:0] op_field(input logic [59:0] v, input int off, input int w);
        logic [59:0] sh;
        sh = v >> off;
        return sh[5:0] & 6'((1 << w) - 1);
    endfunction

endpackage

// File: rtl/expr_seq_lfsr64.sv
// expr_seq_lfsr64: 64-bit Fibonacci LFSR with synchronous reload and advance.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (state <= seed)
//   load           : reload the (zero-guarded) seed; wins over advance
//   advance        : step the LFSR once
//   value[OUT_W-1:0] : low OUT_W bits of the current state
module expr_seq_lfsr64
    import expr_seq_pkg::*;
#(
    parameter int          OUT_W = 60,
    parameter logic [63:0] SEED  = LFSR_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    output logic [OUT_W-1:0] value
);

    localparam logic [63:0] INIT = lfsr64_seed(SEED);

    logic [63:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= INIT;
        end else if (load) begin
            lfsr <= INIT;
        end else if (advance) begin
            lfsr <= lfsr64_next(lfsr);
        end
    end

    assign value = lfsr[OUT_W-1:0];

endmodule

// File: rtl/expr_vector_sequencer.sv
// expr_vector_sequencer: equivalence-check controller around a DUT/golden pair.
// Drives LFSR operand vectors to both instances, waits SETTLE_CYCLES, compares
// the two results and keeps mismatch statistics.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : control pulses (see below)
//   op_vec[OP_W-1:0]    : operand vector to both instances
//   dut_y, ref_y [Y_W]  : results compared in CHECK
//   busy, done, pass    : status (pass valid while done)
//   vec_cnt, mismatch_cnt, first_fail_idx [16], first_fail_vec [OP_W] : results
// Control: start is sampled only in IDLE or DONE and begins a reseeded run;
// abort is sampled every cycle, beats start, freezes the datapath for that
// cycle and returns to IDLE with counters kept for inspection.
// Optional build macro: EXPR_SEQ_STOP_ON_FAIL_EN ends the run at the first
// mismatching vector.
module expr_vector_sequencer
    import expr_seq_pkg::*;
#(
    parameter int          OP_W          = 60,
    parameter int          Y_W           = 90,
    parameter int          NUM_VECTORS   = 1024,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [63:0] SEED          = 64'h1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [OP_W-1:0] op_vec,
    input  logic [Y_W-1:0]  dut_y,
    input  logic [Y_W-1:0]  ref_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     vec_cnt,
    output logic [15:0]     mismatch_cnt,
    output logic [15:0]     first_fail_idx,
    output logic [OP_W-1:0] first_fail_vec
);

    localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  SETTLE_LD = 4'(SETTLE_CYCLES);

    seq_state_t      state, state_next;
    logic [3:0]      settle_cnt;
    logic [OP_W-1:0] lfsr_val;
    logic            run_start;
    logic            mismatch;
    logic            last_vec;
    logic            stop_now;

    // !== so that X/Z on dut_y is reported as a mismatch in simulation.
    assign mismatch  = (dut_y !== ref_y);
    assign last_vec  = (vec_cnt == LAST_IDX);
    assign run_start = start && !abort && ((state == IDLE) || (state == DONE));

`ifdef EXPR_SEQ_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    expr_seq_lfsr64 #(
        .OUT_W (OP_W),
        .SEED  (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (run_start),
        .advance ((state == DRIVE) && !abort),
        .value   (lfsr_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_next = DRIVE;
                DRIVE:      state_next = (SETTLE_LD != 4'd0) ? SETTLE : CHECK;
                // Counter holds the remaining settle cycles including this one.
                SETTLE:     if (settle_cnt <= 4'd1) state_next = CHECK;
                CHECK:      state_next = (last_vec || stop_now) ? DONE : DRIVE;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vec         <= '0;
            settle_cnt     <= '0;
            vec_cnt        <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            first_fail_vec <= '0;
        end else if (run_start) begin
            vec_cnt        <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            first_fail_vec <= '0;
        end else if (!abort) begin
            case (state)
                DRIVE: begin
                    op_vec     <= lfsr_val;
                    settle_cnt <= SETTLE_LD;
                end
                SETTLE: settle_cnt <= settle_cnt - 4'd1;
                CHECK: begin
                    if (mismatch) begin
                        if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
                        if (mismatch_cnt == 16'h0) begin
                            first_fail_idx <= vec_cnt;
                            first_fail_vec <= op_vec;
                        end
                    end
                    if (!last_vec && !stop_now) vec_cnt <= vec_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (mismatch_cnt == 16'h0);

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// tb_expr_vector_sequencer: directed checks of expr_vector_sequencer.
// Four instances share clk/rst_n:
//   u0 : 16 vectors, settle 2, identical models
//   u1 : 8 vectors, settle 2, golden y[0] inverted when op_vec[0]
//   u2 : 1 vector, settle 0, identical models
//   u3 : 8 vectors, settle 2, golden y[0] inverted when op_vec[3]
// With seed 1 the LFSR feedback stays 0 for the first 59 steps, so vector k
// is 1<<k; expected values below follow from that.
module tb_expr_vector_sequencer;
    import expr_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start_v;
    logic [3:0]  abort_v;
    logic [3:0]  busy_v, done_v, pass_v;
    logic [59:0] op_vec_v [4];
    logic [89:0] dut_y_v  [4];
    logic [89:0] ref_y_v  [4];
    logic [15:0] vec_cnt_v[4];
    logic [15:0] mm_v     [4];
    logic [15:0] ffi_v    [4];
    logic [59:0] ffv_v    [4];
    logic [59:0] cap      [16];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    always #5 clk = ~clk;

    // Stand-in expression datapath: sum of a_i*b_i over the unpacked fields.
    function automatic logic [89:0] expr_f(input logic [59:0] op);
        logic [29:0] acc;
        acc = 30'(op_field(op, A0_OFF, A0_W)) * 30'(op_field(op, B0_OFF, B0_W))
            + 30'(op_field(op, A1_OFF, A1_W)) * 30'(op_field(op, B1_OFF, B1_W))
            + 30'(op_field(op, A2_OFF, A2_W)) * 30'(op_field(op, B2_OFF, B2_W))
            + 30'(op_field(op, A3_OFF, A3_W)) * 30'(op_field(op, B3_OFF, B3_W))
            + 30'(op_field(op, A4_OFF, A4_W)) * 30'(op_field(op, B4_OFF, B4_W))
            + 30'(op_field(op, A5_OFF, A5_W)) * 30'(op_field(op, B5_OFF, B5_W));
        return {acc, op};
    endfunction

    assign dut_y_v[0] = expr_f(op_vec_v[0]);
    assign dut_y_v[1] = expr_f(op_vec_v[1]);
    assign dut_y_v[2] = expr_f(op_vec_v[2]);
    assign dut_y_v[3] = expr_f(op_vec_v[3]);
    assign ref_y_v[0] = dut_y_v[0];
    assign ref_y_v[1] = dut_y_v[1] ^ {89'b0, op_vec_v[1][0]};
    assign ref_y_v[2] = dut_y_v[2];
    assign ref_y_v[3] = dut_y_v[3] ^ {89'b0, op_vec_v[3][3]};

    expr_vector_sequencer #(.NUM_VECTORS(16), .SETTLE_CYCLES(2), .SEED(64'h1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .op_vec(op_vec_v[0]), .dut_y(dut_y_v[0]), .ref_y(ref_y_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .vec_cnt(vec_cnt_v[0]), .mismatch_cnt(mm_v[0]),
        .first_fail_idx(ffi_v[0]), .first_fail_vec(ffv_v[0]));

    expr_vector_sequencer #(.NUM_VECTORS(8), .SETTLE_CYCLES(2), .SEED(64'h1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .op_vec(op_vec_v[1]), .dut_y(dut_y_v[1]), .ref_y(ref_y_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .vec_cnt(vec_cnt_v[1]), .mismatch_cnt(mm_v[1]),
        .first_fail_idx(ffi_v[1]), .first_fail_vec(ffv_v[1]));

    expr_vector_sequencer #(.NUM_VECTORS(1), .SETTLE_CYCLES(0), .SEED(64'h0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
        .op_vec(op_vec_v[2]), .dut_y(dut_y_v[2]), .ref_y(ref_y_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .vec_cnt(vec_cnt_v[2]), .mismatch_cnt(mm_v[2]),
        .first_fail_idx(ffi_v[2]), .first_fail_vec(ffv_v[2]));

    expr_vector_sequencer #(.NUM_VECTORS(8), .SETTLE_CYCLES(2), .SEED(64'h1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .abort(abort_v[3]),
        .op_vec(op_vec_v[3]), .dut_y(dut_y_v[3]), .ref_y(ref_y_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
        .vec_cnt(vec_cnt_v[3]), .mismatch_cnt(mm_v[3]),
        .first_fail_idx(ffi_v[3]), .first_fail_vec(ffv_v[3]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start on instance idx; count edges after the start edge until done.
    task automatic run_timed(input int idx, input int budget, output int cycles);
        @(negedge clk); start_v[idx] = 1'b1;
        @(negedge clk); start_v[idx] = 1'b0;
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles < 16) cap[cycles] = op_vec_v[idx];
            if (done_v[idx]) break;
        end
        if (!done_v[idx]) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_zero(input string tag, input int idx);
        check({tag, "_busy"}, 64'(busy_v[idx]), 64'd0);
        check({tag, "_done"}, 64'(done_v[idx]), 64'd0);
        check({tag, "_pass"}, 64'(pass_v[idx]), 64'd0);
        check({tag, "_vec_cnt"}, 64'(vec_cnt_v[idx]), 64'd0);
        check({tag, "_mm"}, 64'(mm_v[idx]), 64'd0);
        check({tag, "_op_vec"}, 64'(op_vec_v[idx]), 64'd0);
        check({tag, "_ffi"}, 64'(ffi_v[idx]), 64'd0);
        check({tag, "_ffv"}, 64'(ffv_v[idx]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        abort_v = '0;
        #12;
        check_zero("reset", 0);
        @(negedge clk); rst_n = 1'b1;

        // Full clean run: 16 vectors * 4 cycles.
        run_timed(0, 200, cyc);
        check("u0_cycles", 64'(cyc), 64'd64);
        check("u0_vec0", 64'(cap[1]), 64'h1);
        check("u0_vec1", 64'(cap[5]), 64'h2);
        check("u0_vec2", 64'(cap[9]), 64'h4);
        check("u0_pass", 64'(pass_v[0]), 64'd1);
        check("u0_mm", 64'(mm_v[0]), 64'd0);
        check("u0_vec_cnt", 64'(vec_cnt_v[0]), 64'd15);
        check("u0_busy_done", 64'(busy_v[0]), 64'd0);
        check("u0_last_op", 64'(op_vec_v[0]), 64'h8000);
        @(posedge clk); #1;
        check("u0_done_hold", 64'(done_v[0]), 64'd1);
        check("u0_op_hold", 64'(op_vec_v[0]), 64'h8000);

        // Fault on vector 0; run twice to confirm the rerun clears counters.
        for (int r = 0; r < 2; r++) begin
            run_timed(1, 200, cyc);
            check("u1_cycles", 64'(cyc), 64'd32);
            check("u1_mm", 64'(mm_v[1]), 64'd1);
            check("u1_ffi", 64'(ffi_v[1]), 64'd0);
            check("u1_ffv", 64'(ffv_v[1]), 64'h1);
            check("u1_pass", 64'(pass_v[1]), 64'd0);
            check("u1_vec_cnt", 64'(vec_cnt_v[1]), 64'd7);
        end

        // Single vector, no settle, zero seed replaced by 1.
        run_timed(2, 20, cyc);
        check("u2_cycles", 64'(cyc), 64'd2);
        check("u2_pass", 64'(pass_v[2]), 64'd1);
        check("u2_vec_cnt", 64'(vec_cnt_v[2]), 64'd0);
        check("u2_op_vec", 64'(op_vec_v[2]), 64'h1);

        // Fault on vector 3.
        run_timed(3, 200, cyc);
`ifdef EXPR_SEQ_STOP_ON_FAIL_EN
        check("u3_cycles", 64'(cyc), 64'd16);
        check("u3_vec_cnt", 64'(vec_cnt_v[3]), 64'd3);
        check("u3_op_vec", 64'(op_vec_v[3]), 64'h8);
`else
        check("u3_cycles", 64'(cyc), 64'd32);
        check("u3_vec_cnt", 64'(vec_cnt_v[3]), 64'd7);
        check("u3_op_vec", 64'(op_vec_v[3]), 64'h80);
`endif
        check("u3_mm", 64'(mm_v[3]), 64'd1);
        check("u3_ffi", 64'(ffi_v[3]), 64'd3);
        check("u3_ffv", 64'(ffv_v[3]), 64'h8);
        check("u3_pass", 64'(pass_v[3]), 64'd0);

        // Abort in the first SETTLE cycle of vector 5 (rerun from DONE).
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        check("pre_abort_vec_cnt", 64'(vec_cnt_v[0]), 64'd5);
        check("pre_abort_busy", 64'(busy_v[0]), 64'd1);
        @(negedge clk); abort_v[0] = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy_v[0]), 64'd0);
        check("abort_done", 64'(done_v[0]), 64'd0);
        check("abort_vec_cnt", 64'(vec_cnt_v[0]), 64'd5);
        @(negedge clk); abort_v[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_stays_idle", 64'(busy_v[0]), 64'd0);

        // Restart after abort.
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        check("restart_vec_cnt", 64'(vec_cnt_v[0]), 64'd0);
        check("restart_busy", 64'(busy_v[0]), 64'd1);
        @(posedge clk); #1;
        check("restart_op_vec", 64'(op_vec_v[0]), 64'h1);

        // Back to IDLE, then start and abort together.
        @(negedge clk); abort_v[0] = 1'b1;
        @(negedge clk); abort_v[0] = 1'b0;
        @(negedge clk); start_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0; abort_v[0] = 1'b0;
        @(posedge clk); #1;
        check("start_abort_busy", 64'(busy_v[0]), 64'd0);
        check("start_abort_done", 64'(done_v[0]), 64'd0);

        // Start while busy is ignored.
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); start_v[0] = 1'b1;
        @(posedge clk); #1;
        check("start_busy_vec_cnt", 64'(vec_cnt_v[0]), 64'd2);
        @(negedge clk); start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("start_busy_vec_cnt_next", 64'(vec_cnt_v[0]), 64'd3);
        check("start_busy_op_vec", 64'(op_vec_v[0]), 64'h4);

        // Asynchronous reset in the middle of CHECK of vector 3.
        repeat (3) @(posedge clk);
        #3;
        check("pre_reset_busy", 64'(busy_v[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset", 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", 64'(busy_v[0]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
